// File: rtl/fighter_arena.sv
// rtl/fighter_arena.sv - two-fighter arena: tick-paced movement, attack FSMs, hits, shields, round end
// Optional shield regeneration is enabled by defining FIGHTER_SHIELD_REGEN_EN.
module fighter_arena #(
  parameter int ARENA_W   = 1024,
  parameter int CHAR_W    = 128,
  parameter int HP_MAX    = 15,
  parameter int SH_MAX    = 15,
  parameter int DMG       = 3,
  parameter int REACH     = 16,
  parameter int TICK_DIV  = 800000,
  parameter int WINDUP_T  = 4,
  parameter int ACTIVE_T  = 2,
  parameter int RECOVER_T = 6,
  parameter int REGEN_T   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [6:0]                 p1_inputs,
  input  logic [6:0]                 p2_inputs,
  output logic [$clog2(ARENA_W)-1:0] p1_x,
  output logic [$clog2(ARENA_W)-1:0] p2_x,
  output logic [7:0]                 p1_health,
  output logic [7:0]                 p2_health,
  output logic [7:0]                 p1_shield,
  output logic [7:0]                 p2_shield,
  output logic [2:0]                 p1_action,
  output logic [2:0]                 p2_action,
  output logic                       round_over,
  output logic [1:0]                 winner
);
  localparam int XW = $clog2(ARENA_W);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = 16;
  localparam int RW = $clog2(REGEN_T + 1);

  localparam logic [XW:0]   CW_E    = (XW+1)'(CHAR_W);
  localparam logic [XW:0]   REACH_E = (XW+1)'(REACH);
  localparam logic [XW-1:0] XMAX    = XW'(ARENA_W - CHAR_W);
  localparam logic [XW-1:0] P1_X0   = XW'(ARENA_W / 3 - CHAR_W / 2);
  localparam logic [XW-1:0] P2_X0   = XW'(2 * ARENA_W / 3 - CHAR_W / 2);

  typedef enum logic [1:0] {PH_IDLE, PH_WINDUP, PH_ACTIVE, PH_RECOVER} phase_e;

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick;
  logic [XW-1:0] x_q    [2];
  logic [XW-1:0] x_d    [2];
  logic [7:0]    hp_q   [2];
  logic [7:0]    hp_d   [2];
  logic [7:0]    sh_q   [2];
  logic [7:0]    sh_d   [2];
  phase_e        ph_q   [2];
  phase_e        ph_d   [2];
  logic [PW-1:0] pcnt_q [2];
  logic [PW-1:0] pcnt_d [2];
  logic [RW-1:0] rcnt_q [2];
  logic [RW-1:0] rcnt_d [2];
  logic [2:0]    act_q  [2];
  logic [2:0]    act_d  [2];
  logic [1:0]    atk_prev_q, atk_prev_d;
  logic          round_over_q, round_over_d;
  logic [1:0]    winner_q, winner_d;

  logic [1:0]    left, right, atk, hold_sh, shld, is_idle, trig, mv, def_sh, hit;
  logic [XW:0]   gap;
  logic          unused_inputs;

  function automatic logic [7:0] sat_sub(input logic [7:0] v);
    return (v > 8'(DMG)) ? v - 8'(DMG) : 8'd0;
  endfunction

  assign unused_inputs = ^{p1_inputs[4:3], p1_inputs[0], p2_inputs[4:3], p2_inputs[0]};
  assign left    = {p2_inputs[1], p1_inputs[1]};
  assign right   = {p2_inputs[2], p1_inputs[2]};
  assign atk     = {p2_inputs[5], p1_inputs[5]};
  assign hold_sh = {p2_inputs[6], p1_inputs[6]};

  // An empty shield counts as not held for every purpose.
  assign shld    = hold_sh & {sh_q[1] != 8'd0, sh_q[0] != 8'd0};
  assign is_idle = {ph_q[1] == PH_IDLE, ph_q[0] == PH_IDLE};
  assign trig    = atk & ~atk_prev_q & is_idle;
  assign mv      = is_idle & ~shld & ~trig & (left ^ right);
  assign def_sh  = shld & is_idle;
  assign gap     = {1'b0, x_q[1]} - {1'b0, x_q[0]} - CW_E;
  assign tick    = (tcnt_q == TW'(TICK_DIV - 1));

  always_comb begin
    tcnt_d       = tick ? '0 : tcnt_q + 1'b1;
    round_over_d = round_over_q;
    winner_d     = winner_q;
    atk_prev_d   = atk_prev_q;
    hit          = '0;
    for (int i = 0; i < 2; i++) begin
      x_d[i]    = x_q[i];
      hp_d[i]   = hp_q[i];
      sh_d[i]   = sh_q[i];
      ph_d[i]   = ph_q[i];
      pcnt_d[i] = pcnt_q[i];
      rcnt_d[i] = rcnt_q[i];
      act_d[i]  = act_q[i];
    end

    if (tick && !round_over_q) begin
      atk_prev_d = atk;
      for (int i = 0; i < 2; i++) begin
        case (ph_q[i])
          PH_IDLE: begin
            if (trig[i]) begin
              ph_d[i]   = PH_WINDUP;
              pcnt_d[i] = '0;
            end
          end
          PH_WINDUP: begin
            if (pcnt_q[i] == PW'(WINDUP_T - 1)) begin
              ph_d[i]   = PH_ACTIVE;
              pcnt_d[i] = '0;
              hit[i]    = (gap <= REACH_E);
            end else begin
              pcnt_d[i] = pcnt_q[i] + 1'b1;
            end
          end
          PH_ACTIVE: begin
            if (pcnt_q[i] == PW'(ACTIVE_T - 1)) begin
              ph_d[i]   = PH_RECOVER;
              pcnt_d[i] = '0;
            end else begin
              pcnt_d[i] = pcnt_q[i] + 1'b1;
            end
          end
          default: begin
            if (pcnt_q[i] == PW'(RECOVER_T - 1)) begin
              ph_d[i]   = PH_IDLE;
              pcnt_d[i] = '0;
            end else begin
              pcnt_d[i] = pcnt_q[i] + 1'b1;
            end
          end
        endcase
`ifdef FIGHTER_SHIELD_REGEN_EN
        if (shld[i]) begin
          rcnt_d[i] = '0;
        end else if (rcnt_q[i] == RW'(REGEN_T - 1)) begin
          rcnt_d[i] = '0;
          if (sh_q[i] < 8'(SH_MAX)) sh_d[i] = sh_q[i] + 8'd1;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 1'b1;
        end
`endif
      end

      // p1 resolves first; p2 then sees p1's updated position.
      if (mv[0]) begin
        if (left[0]) begin
          if (x_q[0] != '0) x_d[0] = x_q[0] - 1'b1;
        end else if (gap != '0) begin
          x_d[0] = x_q[0] + 1'b1;
        end
      end
      if (mv[1]) begin
        if (right[1]) begin
          if (x_q[1] != XMAX) x_d[1] = x_q[1] + 1'b1;
        end else if ({1'b0, x_q[1]} > {1'b0, x_d[0]} + CW_E) begin
          x_d[1] = x_q[1] - 1'b1;
        end
      end

      if (hit[0]) begin
        if (def_sh[1]) sh_d[1] = sat_sub(sh_q[1]);
        else           hp_d[1] = sat_sub(hp_q[1]);
      end
      if (hit[1]) begin
        if (def_sh[0]) sh_d[0] = sat_sub(sh_q[0]);
        else           hp_d[0] = sat_sub(hp_q[0]);
      end

      for (int i = 0; i < 2; i++) begin
        if (hp_d[i] == 8'd0) begin
          act_d[i] = 3'd7;
        end else begin
          case (ph_d[i])
            PH_WINDUP:  act_d[i] = 3'd4;
            PH_ACTIVE:  act_d[i] = 3'd5;
            PH_RECOVER: act_d[i] = 3'd6;
            default: begin
              if (shld[i])                    act_d[i] = 3'd3;
              else if (left[i] && !right[i])  act_d[i] = 3'd1;
              else if (right[i] && !left[i])  act_d[i] = 3'd2;
              else                            act_d[i] = 3'd0;
            end
          endcase
        end
      end

      if (hp_d[0] == 8'd0 || hp_d[1] == 8'd0) begin
        round_over_d = 1'b1;
        winner_d     = {hp_d[0] == 8'd0, hp_d[1] == 8'd0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q       <= '0;
      round_over_q <= 1'b0;
      winner_q     <= 2'b00;
      atk_prev_q   <= '0;
      x_q[0]       <= P1_X0;
      x_q[1]       <= P2_X0;
      for (int i = 0; i < 2; i++) begin
        hp_q[i]   <= 8'(HP_MAX);
        sh_q[i]   <= 8'(SH_MAX);
        ph_q[i]   <= PH_IDLE;
        pcnt_q[i] <= '0;
        rcnt_q[i] <= '0;
        act_q[i]  <= 3'd0;
      end
    end else begin
      tcnt_q       <= tcnt_d;
      round_over_q <= round_over_d;
      winner_q     <= winner_d;
      atk_prev_q   <= atk_prev_d;
      for (int i = 0; i < 2; i++) begin
        x_q[i]    <= x_d[i];
        hp_q[i]   <= hp_d[i];
        sh_q[i]   <= sh_d[i];
        ph_q[i]   <= ph_d[i];
        pcnt_q[i] <= pcnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  assign p1_x       = x_q[0];
  assign p2_x       = x_q[1];
  assign p1_health  = hp_q[0];
  assign p2_health  = hp_q[1];
  assign p1_shield  = sh_q[0];
  assign p2_shield  = sh_q[1];
  assign p1_action  = act_q[0];
  assign p2_action  = act_q[1];
  assign round_over = round_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_fighter_arena.sv
// tb/tb_fighter_arena.sv - directed and randomized bench for fighter_arena against a tick-level model
module tb_fighter_arena;
  localparam int TD = 4, AW = 1024, CW = 128, HP = 15, SH = 15, D = 3, REACH = 16;
  localparam int W = 4, A = 2, R = 6, TOT = W + A + R, RG = 32;
  localparam logic [6:0] BL = 7'b0000010, BR = 7'b0000100, BA = 7'b0100000, BS = 7'b1000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] p1_inputs = '0, p2_inputs = '0;
  logic [9:0] p1_x, p2_x;
  logic [7:0] p1_health, p2_health, p1_shield, p2_shield;
  logic [2:0] p1_action, p2_action;
  logic       round_over;
  logic [1:0] winner;

  fighter_arena #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .p1_inputs(p1_inputs), .p2_inputs(p2_inputs),
    .p1_x(p1_x), .p2_x(p2_x), .p1_health(p1_health), .p2_health(p2_health),
    .p1_shield(p1_shield), .p2_shield(p2_shield), .p1_action(p1_action),
    .p2_action(p2_action), .round_over(round_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int mx[2], mhp[2], msh[2], mstart[2], mrc[2], mact[2];
  bit mprev[2];
  bit mover, mvalid = 1'b0;
  int mwin, cyc, tn;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx[0] = AW / 3 - CW / 2;
    mx[1] = 2 * AW / 3 - CW / 2;
    for (int i = 0; i < 2; i++) begin
      mhp[i] = HP; msh[i] = SH; mstart[i] = -1; mrc[i] = 0; mact[i] = 0; mprev[i] = 1'b0;
    end
    mover = 1'b0; mwin = 0; cyc = 0; tn = 0; mvalid = 1'b1;
  endtask

  // Attack phase is derived from ticks elapsed since the triggering tick.
  task automatic model_tick();
    logic [6:0] in[2];
    bit l[2], r[2], a[2], s[2], idle[2], trig[2], land[2];
    int gap, e;
    in[0] = p1_inputs; in[1] = p2_inputs;
    tn++;
    if (mover) return;
    gap = mx[1] - mx[0] - CW;
    for (int i = 0; i < 2; i++) begin
      l[i] = in[i][1]; r[i] = in[i][2]; a[i] = in[i][5];
      s[i] = in[i][6] && msh[i] > 0;
      idle[i] = (mstart[i] < 0) || (tn - 1 - mstart[i] >= TOT);
      trig[i] = idle[i] && a[i] && !mprev[i];
      land[i] = (mstart[i] >= 0) && (tn - mstart[i] == W) && (gap <= REACH);
    end
    if (idle[0] && !s[0] && !trig[0] && l[0] != r[0]) begin
      if (l[0]) mx[0] -= (mx[0] > 0) ? 1 : 0;
      else      mx[0] += (gap > 0) ? 1 : 0;
    end
    if (idle[1] && !s[1] && !trig[1] && l[1] != r[1]) begin
      if (r[1]) mx[1] += (mx[1] < AW - CW) ? 1 : 0;
      else      mx[1] -= (mx[1] - mx[0] - CW > 0) ? 1 : 0;
    end
`ifdef FIGHTER_SHIELD_REGEN_EN
    for (int i = 0; i < 2; i++) begin
      if (s[i]) mrc[i] = 0;
      else begin
        mrc[i]++;
        if (mrc[i] == RG) begin
          mrc[i] = 0;
          if (msh[i] < SH) msh[i]++;
        end
      end
    end
`endif
    for (int i = 0; i < 2; i++) begin
      if (land[i]) begin
        if (s[1-i] && idle[1-i]) msh[1-i] = (msh[1-i] > D) ? msh[1-i] - D : 0;
        else                     mhp[1-i] = (mhp[1-i] > D) ? mhp[1-i] - D : 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      mprev[i] = a[i];
      if (trig[i]) mstart[i] = tn;
    end
    for (int i = 0; i < 2; i++) begin
      e = tn - mstart[i];
      if (mhp[i] == 0)                   mact[i] = 7;
      else if (mstart[i] >= 0 && e < TOT) mact[i] = (e < W) ? 4 : (e < W + A) ? 5 : 6;
      else if (s[i])                     mact[i] = 3;
      else if (l[i] && !r[i])            mact[i] = 1;
      else if (r[i] && !l[i])            mact[i] = 2;
      else                               mact[i] = 0;
    end
    if (mhp[0] == 0 || mhp[1] == 0) begin
      mover = 1'b1;
      mwin = ((mhp[0] == 0) ? 2 : 0) + ((mhp[1] == 0) ? 1 : 0);
    end
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else begin
      cyc++;
      if (cyc % TD == 0) model_tick();
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("p1_x", p1_x, mx[0]);
      check("p2_x", p2_x, mx[1]);
      check("p1_health", p1_health, mhp[0]);
      check("p2_health", p2_health, mhp[1]);
      check("p1_shield", p1_shield, msh[0]);
      check("p2_shield", p2_shield, msh[1]);
      check("p1_action", p1_action, mact[0]);
      check("p2_action", p2_action, mact[1]);
      check("round_over", round_over, mover);
      check("winner", winner, mwin);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_p1_x"}, p1_x, 277);
    check({tag, "_p2_x"}, p2_x, 618);
    check({tag, "_p1_hp"}, p1_health, 15);
    check({tag, "_p2_hp"}, p2_health, 15);
    check({tag, "_p1_sh"}, p1_shield, 15);
    check({tag, "_p2_sh"}, p2_shield, 15);
    check({tag, "_acts"}, {p1_action, p2_action}, 0);
    check({tag, "_over"}, round_over, 0);
    check({tag, "_winner"}, winner, 0);
  endtask

  function automatic logic [6:0] rand_in(input bit is_p1);
    logic [6:0] v;
    v = 7'($urandom);
    if ($urandom_range(0, 2) != 0) begin
      v[1] = !is_p1;
      v[2] = is_p1;
    end
    v[6] = ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  initial begin
    do_reset();
    check_reset_state("rst");

    p1_inputs = BR; run_ticks(300);
    check("walk_p1_stop", p1_x, 490);
    check("walk_p2_still", p2_x, 618);
    p1_inputs = '0; p2_inputs = BR; run_ticks(400);
    check("walk_p2_edge", p2_x, 896);

    p2_inputs = '0; p1_inputs = BL | BR; run_ticks(10);
    check("lr_p1_x", p1_x, 490);
    check("lr_p1_act", p1_action, 0);

    p1_inputs = '0; p2_inputs = BL; run_ticks(277);
    check("close_p2_x", p2_x, 619);
    p1_inputs = BR; p2_inputs = BL; run_ticks(1);
    check("gap1_p1_x", p1_x, 491);
    check("gap1_p2_x", p2_x, 619);

    p1_inputs = '0; p2_inputs = BS; run_ticks(1);
    p1_inputs = BA; run_ticks(4);
    check("sh_before", p2_shield, 15);
    run_ticks(1);
    check("sh_hit_shield", p2_shield, 12);
    check("sh_hit_health", p2_health, 15);
    check("sh_p1_active", p1_action, 5);
    p1_inputs = '0; p2_inputs = '0;
`ifdef FIGHTER_SHIELD_REGEN_EN
    run_ticks(31);
    check("regen_early", p2_shield, 12);
    run_ticks(1);
    check("regen_step", p2_shield, 13);
`else
    run_ticks(32);
    check("no_regen", p2_shield, 12);
`endif

    p1_inputs = BA; run_ticks(4);
    check("hit_before", p2_health, 15);
    run_ticks(1);
    check("hit_first", p2_health, 12);
    run_ticks(30);
    check("hit_no_retrig", p2_health, 12);
    p1_inputs = '0; run_ticks(1);

    for (int k = 0; k < 4; k++) begin
      p1_inputs = BA; run_ticks(1);
      p1_inputs = '0; run_ticks(12);
    end
    check("ko_p2_hp", p2_health, 0);
    check("ko_over", round_over, 1);
    check("ko_winner", winner, 1);
    check("ko_p2_act", p2_action, 7);
    for (int k = 0; k < 20; k++) begin
      p1_inputs = 7'($urandom); p2_inputs = 7'($urandom); run_ticks(1);
    end
    check("frz_p1_x", p1_x, 491);
    check("frz_p2_x", p2_x, 619);
    check("frz_p1_hp", p1_health, 15);
    check("frz_p2_hp", p2_health, 0);
    check("frz_over", round_over, 1);
    check("frz_winner", winner, 1);
    p1_inputs = '0; p2_inputs = '0;
    do_reset();
    check_reset_state("rst2");

    for (int rnd = 0; rnd < 3; rnd++) begin
      do_reset();
      p1_inputs = BR; p2_inputs = '0; run_ticks(180);
      for (int seg = 0; seg < 250 && !mover; seg++) begin
        p1_inputs = rand_in(1'b1);
        p2_inputs = rand_in(1'b0);
        if ($urandom_range(0, 99) == 0) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
        end
        repeat ($urandom_range(1, 6) * TD) @(negedge clk);
      end
      run_ticks(10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
